chroma_key_ctrl: RTL and testbench

// Sequencer/configurator for the chroma-key mixer. Runs an on-demand green-threshold

---
 rtl/chroma_key_ctrl.sv | 131 +++++++++++++
 tb/tb_chroma_key_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_key_ctrl.sv
// Chroma-key mixer controller: green-threshold calibration sequencer plus
// frame-synchronous commit of the threshold and the video/image enables.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for a calibration request
// WAIT_FRAME | request accepted, waiting for frame start to begin sampling
// ACCUM      | summing windowed green samples until N are collected
// COMPUTE    | deriving the calibrated threshold from the sample mean
module chroma_key_ctrl #(
   parameter int DATA_W          = 10,
   parameter int WIN_LOG2        = 6,
   parameter int TH_DEFAULT      = 512,
   parameter int TH_MARGIN_SHIFT = 3
) (
   input  logic              iCLK27,
   input  logic              iRST_N,
   input  logic              iVSync,
   input  logic              iPixValid,
   input  logic              iInWindow,
   input  logic [DATA_W-1:0] iGreen,
   input  logic              iCalReq,
   input  logic              iAutoMode,
   input  logic [DATA_W-1:0] iManualTh,
   input  logic              iVideoReq,
   input  logic              iImageReq,
   output logic [DATA_W-1:0] oThG,
   output logic              oVideoEnable,
   output logic              oImageEnable,
   output logic              oCalBusy,
   output logic              oCalDone,
   output logic              oCalFail
);

   localparam int ACC_W = DATA_W + WIN_LOG2;
   localparam int CNT_W = WIN_LOG2 + 1;
   localparam int N     = 1 << WIN_LOG2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_ACCUM,
      S_COMPUTE
   } state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  cal_th;
   logic [ACC_W-1:0]   mean_w;
   logic [ACC_W-1:0]   th_w;
   logic               sample;

   // A pixel coinciding with frame start is never counted.
   assign sample = iPixValid & iInWindow & ~iVSync;

   // Threshold = mean minus a fractional margin; kept full width so the zero
   // test sees every bit before truncation.
   always_comb begin
      mean_w = acc >> WIN_LOG2;
      th_w   = mean_w - (mean_w >> TH_MARGIN_SHIFT);
   end

   // Calibration sequencer with registered status outputs.
   always_ff @(posedge iCLK27) begin
      if (!iRST_N) begin
         state    <= S_IDLE;
         acc      <= '0;
         cnt      <= '0;
         cal_th   <= DATA_W'(TH_DEFAULT);
         oCalBusy <= 1'b0;
         oCalDone <= 1'b0;
         oCalFail <= 1'b0;
      end else begin
         oCalDone <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iCalReq) begin
                  state    <= S_WAIT_FRAME;
                  oCalBusy <= 1'b1;
                  oCalFail <= 1'b0;
               end
            end
            S_WAIT_FRAME: begin
               if (iVSync) begin
                  state <= S_ACCUM;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            S_ACCUM: begin
               // A new frame before the window filled aborts, even on the Nth pixel.
               if (iVSync) begin
                  state    <= S_IDLE;
                  oCalBusy <= 1'b0;
                  oCalFail <= 1'b1;
               end else if (sample) begin
                  acc <= acc + ACC_W'(iGreen);
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(N - 1))
                     state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               cal_th   <= (th_w == '0) ? DATA_W'(1) : th_w[DATA_W-1:0];
               state    <= S_IDLE;
               oCalBusy <= 1'b0;
               oCalDone <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               oCalBusy <= 1'b0;
            end
         endcase
      end
   end

   // Mixer-facing settings change only at frame start to avoid tearing.
   always_ff @(posedge iCLK27) begin
      if (!iRST_N) begin
         oThG         <= DATA_W'(TH_DEFAULT);
         oVideoEnable <= 1'b0;
         oImageEnable <= 1'b0;
      end else if (iVSync) begin
         oThG         <= iAutoMode ? cal_th : iManualTh;
         oVideoEnable <= iVideoReq;
         oImageEnable <= iImageReq;
      end
   end

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// Bench for chroma_key_ctrl: directed stimulus pushes expected output events
// into a queue; a negedge monitor pops and compares each observed event.
module tb_chroma_key_ctrl;

   localparam int EV_DONE   = 0;
   localparam int EV_CALERR = 1;
   localparam int EV_COMMIT = 2;

   typedef struct {
      int         kind;
      logic [9:0] th;
      logic       ve;
      logic       ie;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vsync, pix_valid, in_window, cal_req, auto_mode, video_req, image_req;
   logic [9:0] green, manual_th;
   logic [9:0] thg;
   logic       video_en, image_en, cal_busy, cal_done, cal_fail;

   int checks = 0;
   int errors = 0;
   ev_t exp_q[$];
   logic mon_en = 1'b0;

   logic [9:0] prev_th;
   logic       prev_ve, prev_ie, prev_fail;

   always #5 clk = ~clk;

   chroma_key_ctrl dut (
      .iCLK27      (clk),
      .iRST_N      (rst_n),
      .iVSync      (vsync),
      .iPixValid   (pix_valid),
      .iInWindow   (in_window),
      .iGreen      (green),
      .iCalReq     (cal_req),
      .iAutoMode   (auto_mode),
      .iManualTh   (manual_th),
      .iVideoReq   (video_req),
      .iImageReq   (image_req),
      .oThG        (thg),
      .oVideoEnable(video_en),
      .oImageEnable(image_en),
      .oCalBusy    (cal_busy),
      .oCalDone    (cal_done),
      .oCalFail    (cal_fail)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int th, input logic ve, input logic ie);
      ev_t e;
      e.kind = kind;
      e.th   = 10'(th);
      e.ve   = ve;
      e.ie   = ie;
      exp_q.push_back(e);
   endtask

   // Pops the oldest expected event and compares it with what was observed.
   task automatic observe(input int kind, input logic [9:0] th, input logic ve, input logic ie);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d th %0d ve %0d ie %0d, expected none",
                  kind, th, ve, ie);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind ||
             (kind == EV_COMMIT && (e.th != th || e.ve != ve || e.ie != ie))) begin
            errors++;
            $display("FAIL event_%0d: got kind %0d th %0d ve %0d ie %0d, expected kind %0d th %0d ve %0d ie %0d",
                     checks, kind, th, ve, ie, e.kind, e.th, e.ve, e.ie);
         end
      end
   endtask

   // Monitor: turns output activity into events on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cal_done === 1'b1)
            observe(EV_DONE, 10'd0, 1'b0, 1'b0);
         if (cal_fail === 1'b1 && prev_fail === 1'b0)
            observe(EV_CALERR, 10'd0, 1'b0, 1'b0);
         if (thg !== prev_th || video_en !== prev_ve || image_en !== prev_ie)
            observe(EV_COMMIT, thg, video_en, image_en);
      end
      prev_th   = thg;
      prev_ve   = video_en;
      prev_ie   = image_en;
      prev_fail = cal_fail;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_vsync();
      vsync = 1'b1;
      tick(1);
      vsync = 1'b0;
   endtask

   task automatic pixels(input int n, input int g);
      pix_valid = 1'b1;
      in_window = 1'b1;
      green     = 10'(g);
      tick(n);
      pix_valid = 1'b0;
      in_window = 1'b0;
   endtask

   task automatic cal_request();
      cal_req = 1'b1;
      tick(1);
      cal_req = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; vsync = 0; pix_valid = 0; in_window = 0; cal_req = 0;
      auto_mode = 1'b1; video_req = 0; image_req = 0; green = '0; manual_th = '0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
      mon_en = 1'b1;

      // Reset state, then a frame start with nothing changed.
      check("rst_thg", thg, 512);
      check("rst_video", video_en, 0);
      check("rst_image", image_en, 0);
      check("rst_busy", cal_busy, 0);
      check("rst_done", cal_done, 0);
      check("rst_calfail", cal_fail, 0);
      do_vsync();
      check("vs_thg", thg, 512);

      // Successful calibration on green=400 -> 350 at next frame.
      cal_request();
      check("busy_wait", cal_busy, 1);
      do_vsync();
      push(EV_DONE, 0, 0, 0);
      pixels(64, 400);
      tick(3);
      check("idle_after_cal", cal_busy, 0);
      check("thg_before_commit", thg, 512);
      push(EV_COMMIT, 350, 0, 0);
      do_vsync();
      check("thg_cal400", thg, 350);

      // Short frame aborts calibration.
      push(EV_COMMIT, 512, 0, 0);
      pulse_reset();
      cal_request();
      do_vsync();
      pixels(10, 300);
      push(EV_CALERR, 0, 0, 0);
      do_vsync();
      tick(1);
      check("short_calfail", cal_fail, 1);
      check("short_busy", cal_busy, 0);
      check("short_thg", thg, 512);

      // Video enable only changes at frame start.
      video_req = 1'b1;
      tick(5);
      check("ve_midframe", video_en, 0);
      push(EV_COMMIT, 512, 1, 0);
      do_vsync();
      check("ve_after_vs", video_en, 1);

      // Request during ACCUM is ignored; calibration completes on 64 samples.
      cal_request();
      check("calfail_cleared", cal_fail, 0);
      check("busy_accept", cal_busy, 1);
      do_vsync();
      pixels(20, 200);
      cal_request();
      push(EV_DONE, 0, 0, 0);
      pixels(44, 200);
      tick(3);
      check("busy_after_ignored_req", cal_busy, 0);

      // Reset in the middle of ACCUM: back to defaults, no completion.
      cal_request();
      push(EV_COMMIT, 175, 1, 0);
      do_vsync();
      pixels(30, 200);
      push(EV_COMMIT, 512, 0, 0);
      pulse_reset();
      video_req = 1'b0;
      check("midrst_busy", cal_busy, 0);
      pixels(40, 200);
      tick(3);
      do_vsync();
      check("midrst_thg", thg, 512);

      // Manual mode, then a zero-green calibration clamps to 1.
      auto_mode = 1'b0;
      manual_th = 10'd300;
      push(EV_COMMIT, 300, 0, 0);
      do_vsync();
      check("manual_thg", thg, 300);
      cal_request();
      do_vsync();
      push(EV_DONE, 0, 0, 0);
      pixels(64, 0);
      tick(3);
      check("manual_hold", thg, 300);
      auto_mode = 1'b1;
      image_req = 1'b1;
      push(EV_COMMIT, 1, 0, 1);
      do_vsync();
      check("clamp_thg", thg, 1);
      check("image_en", image_en, 1);

      // Frame start on the same cycle as the 64th sample wins.
      cal_request();
      do_vsync();
      pixels(63, 100);
      pix_valid = 1'b1;
      in_window = 1'b1;
      push(EV_CALERR, 0, 0, 0);
      do_vsync();
      pix_valid = 1'b0;
      in_window = 1'b0;
      tick(4);
      check("race_calfail", cal_fail, 1);
      check("race_busy", cal_busy, 0);
      check("race_thg", thg, 1);

      tick(2);
      check("events_pending", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
